// File: rtl/rr_shared_mux_arbiter_pkg.sv
// Shared types for the round-robin shared-mux arbiter.
// State encoding and counter width helper.
package rr_shared_mux_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    function automatic int cnt_w(input int burst);
        return (burst > 1) ? $clog2(burst) : 1;
    endfunction

endpackage

// File: rtl/rr_shared_mux_arbiter_pick.sv
// Round-robin pick: rotate by ptr, fixed-priority
// select lowest set bit, then unrotate to an index.
module rr_pick #(
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [SEL_W-1:0] i_ptr,
    output logic [SEL_W-1:0] o_winner,
    output logic             o_any_req
);

    localparam logic [SEL_W:0] NN = (SEL_W+1)'(N);

    logic [2*N-1:0] w_dbl;
    logic [N-1:0]   w_rot;
    logic [SEL_W:0] w_off;
    logic [SEL_W:0] w_sum;

    always_comb begin
        w_dbl = {i_req, i_req};
        w_rot = w_dbl[i_ptr +: N];
        w_off = '0;
        // Descending scan leaves the lowest rotated offset.
        for (int i = N - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = (SEL_W+1)'(i);
            end
        end
        w_sum = {1'b0, i_ptr} + w_off;
        if (w_sum >= NN) begin
            w_sum = w_sum - NN;
        end
    end

    assign o_winner  = w_sum[SEL_W-1:0];
    assign o_any_req = |i_req;

endmodule

// File: rtl/rr_shared_mux_arbiter.sv
// Round-robin arbiter owning one shared N:1 data mux,
// holding each grant for up to BURST accepted beats.
module rr_shared_mux_arbiter
    import rr_shared_mux_arbiter_pkg::*;
#(
    parameter int N     = 4,
    parameter int W     = 8,
    parameter int SEL_W = 2,
    parameter int BURST = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic [N*W-1:0]   req_data,
    output logic [N-1:0]     gnt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [SEL_W-1:0] out_sel,
    output logic             busy
);

    localparam int CW = cnt_w(BURST);
    localparam logic [CW-1:0] LAST = CW'(BURST - 1);
    localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(N - 1);

    state_e           r_state;
    state_e           w_state_nx;
    logic [SEL_W-1:0] r_ptr;
    logic [SEL_W-1:0] w_ptr_nx;
    logic [SEL_W-1:0] r_sel;
    logic [SEL_W-1:0] w_sel_nx;
    logic [SEL_W-1:0] w_sel_inc;
    logic [SEL_W-1:0] w_winner;
    logic [CW-1:0]    r_beat_cnt;
    logic [CW-1:0]    w_beat_nx;
    logic             w_any;
    logic             w_busy;
    logic             w_valid;
    logic [W-1:0]     w_mux;
    logic [N-1:0]     w_onehot;

    rr_pick #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_pick (
        .i_req     (req),
        .i_ptr     (r_ptr),
        .o_winner  (w_winner),
        .o_any_req (w_any)
    );

    // Wrap at N-1, not at the select field width.
    assign w_sel_inc = (r_sel == SEL_MAX) ? '0 : r_sel + 1'b1;
    assign w_busy    = (r_state == ST_BUSY);
    assign w_valid   = w_busy & req[r_sel];

    always_comb begin
        w_mux    = '0;
        w_onehot = '0;
        for (int i = 0; i < N; i++) begin
            if (r_sel == SEL_W'(i)) begin
                w_mux       = req_data[i*W +: W];
                w_onehot[i] = 1'b1;
            end
        end
    end

    assign gnt       = w_busy ? w_onehot : '0;
    assign out_valid = w_valid;
    assign out_data  = w_valid ? w_mux : '0;
    assign out_sel   = r_sel;
    assign busy      = w_busy;

    always_comb begin
        w_state_nx = r_state;
        w_ptr_nx   = r_ptr;
        w_sel_nx   = r_sel;
        w_beat_nx  = r_beat_cnt;
        unique case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_sel_nx   = w_winner;
                    w_beat_nx  = '0;
                    w_state_nx = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!w_valid) begin
                    w_ptr_nx   = w_sel_inc;
                    w_state_nx = ST_IDLE;
                end else if (out_ready) begin
                    if (r_beat_cnt == LAST) begin
                        w_ptr_nx   = w_sel_inc;
                        w_state_nx = ST_IDLE;
                    end else begin
                        w_beat_nx = r_beat_cnt + 1'b1;
                    end
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_sel      <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_ptr      <= w_ptr_nx;
            r_sel      <= w_sel_nx;
            r_beat_cnt <= w_beat_nx;
        end
    end

endmodule

// File: tb/tb_rr_shared_mux_arbiter.sv
// Directed bench: BURST=2 instance plus a BURST=1
// instance sharing the same requester stimulus.
module tb_rr_shared_mux_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic        out_ready;

    logic [3:0]  gnt;
    logic        valid;
    logic [7:0]  data;
    logic [1:0]  sel;
    logic        bsy;

    logic [3:0]  gnt1;
    logic        valid1;
    logic [7:0]  data1;
    logic [1:0]  sel1;
    logic        bsy1;

    int errors;
    int checks;

    rr_shared_mux_arbiter #(
        .N(4), .W(8), .SEL_W(2), .BURST(2)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_data  (req_data),
        .gnt       (gnt),
        .out_valid (valid),
        .out_ready (out_ready),
        .out_data  (data),
        .out_sel   (sel),
        .busy      (bsy)
    );

    rr_shared_mux_arbiter #(
        .N(4), .W(8), .SEL_W(2), .BURST(1)
    ) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_data  (req_data),
        .gnt       (gnt1),
        .out_valid (valid1),
        .out_ready (out_ready),
        .out_data  (data1),
        .out_sel   (sel1),
        .busy      (bsy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle away from it.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req       = 4'b0000;
        req_data  = 32'h0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'b1111;
        #3;
        checks++;
        if (gnt !== 4'b0000 || gnt1 !== 4'b0000) begin
            errors++;
            $display("FAIL reset_gnt got %b/%b want 0000",
                     gnt, gnt1);
        end
        checks++;
        if (valid !== 1'b0 || data !== 8'h00) begin
            errors++;
            $display("FAIL reset_out got v=%b d=%h want 0/00",
                     valid, data);
        end
        checks++;
        if (sel !== 2'd0 || bsy !== 1'b0) begin
            errors++;
            $display("FAIL reset_sel got s=%0d b=%b want 0/0",
                     sel, bsy);
        end
        do_reset();
    endtask

    task automatic test_basic_burst();
        do_reset();
        req       = 4'b0001;
        req_data  = 32'h0000_00A5;
        out_ready = 1'b1;
        #1;
        checks++;
        if (gnt !== 4'b0000) begin
            errors++;
            $display("FAIL basic_idle_gnt got %b want 0000", gnt);
        end
        for (int b = 0; b < 2; b++) begin
            cyc();
            checks++;
            if (gnt !== 4'b0001 || valid !== 1'b1
                || data !== 8'hA5) begin
                errors++;
                $display("FAIL basic_beat%0d got g=%b v=%b d=%h want 0001/1/a5",
                         b, gnt, valid, data);
            end
        end
        req = 4'b1111;
        cyc();
        checks++;
        if (gnt !== 4'b0000 || bsy !== 1'b0) begin
            errors++;
            $display("FAIL basic_bubble got g=%b b=%b want 0000/0",
                     gnt, bsy);
        end
        cyc();
        checks++;
        if (gnt !== 4'b0010) begin
            errors++;
            $display("FAIL basic_ptr1 got %b want 0010", gnt);
        end
        req = 4'b0000;
    endtask

    task automatic test_fairness();
        logic [3:0] exp;
        do_reset();
        req       = 4'b1111;
        req_data  = 32'h4433_2211;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            exp = 4'b0001 << (k % 4);
            cyc();
            checks++;
            if (gnt1 !== exp) begin
                errors++;
                $display("FAIL fair_gnt%0d got %b want %b",
                         k, gnt1, exp);
            end
            cyc();
            checks++;
            if (gnt1 !== 4'b0000) begin
                errors++;
                $display("FAIL fair_bubble%0d got %b want 0000",
                         k, gnt1);
            end
        end
        req = 4'b0000;
    endtask

    task automatic test_wrap();
        do_reset();
        req       = 4'b0100;
        req_data  = 32'h4433_2211;
        out_ready = 1'b1;
        cyc();
        checks++;
        if (gnt1 !== 4'b0100 || data1 !== 8'h33) begin
            errors++;
            $display("FAIL wrap_first got g=%b d=%h want 0100/33",
                     gnt1, data1);
        end
        req = 4'b0101;
        cyc();
        cyc();
        checks++;
        if (gnt1 !== 4'b0001) begin
            errors++;
            $display("FAIL wrap_to0 got %b want 0001", gnt1);
        end
        cyc();
        cyc();
        checks++;
        if (gnt1 !== 4'b0100) begin
            errors++;
            $display("FAIL wrap_then2 got %b want 0100", gnt1);
        end
        req = 4'b0000;
    endtask

    task automatic test_stall();
        do_reset();
        req       = 4'b0010;
        req_data  = 32'h0000_3C00;
        out_ready = 1'b0;
        cyc();
        for (int s = 0; s < 5; s++) begin
            checks++;
            if (gnt !== 4'b0010 || valid !== 1'b1
                || data !== 8'h3C) begin
                errors++;
                $display("FAIL stall_c%0d got g=%b v=%b d=%h want 0010/1/3c",
                         s, gnt, valid, data);
            end
            if (s < 4) cyc();
        end
        out_ready = 1'b1;
        cyc();
        checks++;
        if (gnt !== 4'b0010 || valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_beat2 got g=%b v=%b want 0010/1",
                     gnt, valid);
        end
        cyc();
        checks++;
        if (gnt !== 4'b0000 || bsy !== 1'b0) begin
            errors++;
            $display("FAIL stall_done got g=%b b=%b want 0000/0",
                     gnt, bsy);
        end
        req = 4'b0000;
    endtask

    task automatic test_withdraw();
        do_reset();
        req       = 4'b0100;
        req_data  = 32'h0000_0000;
        out_ready = 1'b0;
        cyc();
        checks++;
        if (gnt !== 4'b0100 || valid !== 1'b1) begin
            errors++;
            $display("FAIL wd_grant got g=%b v=%b want 0100/1",
                     gnt, valid);
        end
        req = 4'b1001;
        #1;
        checks++;
        if (valid !== 1'b0 || data !== 8'h00
            || (gnt[2] & out_ready) !== 1'b0) begin
            errors++;
            $display("FAIL wd_drop got v=%b d=%h want 0/00",
                     valid, data);
        end
        cyc();
        checks++;
        if (bsy !== 1'b0 || gnt !== 4'b0000) begin
            errors++;
            $display("FAIL wd_idle got b=%b g=%b want 0/0000",
                     bsy, gnt);
        end
        out_ready = 1'b1;
        cyc();
        checks++;
        if (gnt !== 4'b1000) begin
            errors++;
            $display("FAIL wd_ptr3 got %b want 1000", gnt);
        end
        req = 4'b0000;
    endtask

    task automatic test_async_reset();
        do_reset();
        req       = 4'b1001;
        req_data  = 32'hD300_00A1;
        out_ready = 1'b1;
        repeat (4) cyc();
        checks++;
        if (gnt !== 4'b1000 || data !== 8'hD3) begin
            errors++;
            $display("FAIL ar_pre got g=%b d=%h want 1000/d3",
                     gnt, data);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (gnt !== 4'b0000 || valid !== 1'b0
            || data !== 8'h00 || bsy !== 1'b0) begin
            errors++;
            $display("FAIL ar_now got g=%b v=%b d=%h want 0000/0/00",
                     gnt, valid, data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        checks++;
        if (gnt !== 4'b0001 || data !== 8'hA1) begin
            errors++;
            $display("FAIL ar_after got g=%b d=%h want 0001/a1",
                     gnt, data);
        end
        req = 4'b0000;
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        rst_n     = 1'b0;
        req       = 4'b0000;
        req_data  = 32'h0;
        out_ready = 1'b0;
        test_reset();
        test_basic_burst();
        test_fairness();
        test_wrap();
        test_stall();
        test_withdraw();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end

endmodule
